// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority picker: first asserted request at or after rr_ptr, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic              any,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand [NumReq];

  // Scan from the far end so the candidate nearest rr_ptr is written last and wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand[k] = IdxW'((int'(rr_ptr) + k) % NumReq);
    end
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async-FIFO write port among
// NumReq requesters; writes are gated by wfull and grants capped at MaxBeats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxBeats  = 16
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic [NumReq-1:0]           req_valid,
  input  logic [NumReq*DataWidth-1:0] req_data,
  input  logic [NumReq-1:0]           req_last,
  output logic [NumReq-1:0]           req_ready,
  input  logic                        wfull,
  output logic                        winc,
  output logic [DataWidth-1:0]        wdata,
  output logic [$clog2(NumReq)-1:0]   grant_id,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int IdxW = idx_width(NumReq);
  localparam int CntW = $clog2(MaxBeats + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MaxBeats - 1);

  arb_state_e      state, state_nxt;
  logic [IdxW-1:0] rr_ptr;
  logic [CntW-1:0] beat_cnt;
  logic            pick_any;
  logic [IdxW-1:0] pick_idx;
  logic            beat;
  logic            cap_hit;
  logic            rel;
  logic            force_rel;

  rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_any) state_nxt = ARB_BUSY;
      ARB_BUSY: if (rel)      state_nxt = ARB_IDLE;
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  // Ready follows wfull combinationally so a full FIFO blocks the write in the same cycle.
  always_comb begin
    req_ready = '0;
    if (state == ARB_BUSY) req_ready[grant_id] = ~wfull;
  end

  assign busy      = (state == ARB_BUSY);
  assign beat      = req_valid[grant_id] & req_ready[grant_id];
  assign winc      = beat;
  assign wdata     = req_data[int'(grant_id) * DataWidth +: DataWidth];
  assign cap_hit   = beat & (beat_cnt == LastCnt);
  assign rel       = beat & (req_last[grant_id] | cap_hit);
  assign force_rel = cap_hit & ~req_last[grant_id];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      pkt_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      pkt_done <= rel;
      // A new overrun outranks a simultaneous clear.
      if (force_rel)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (state == ARB_IDLE && pick_any) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (rel) rr_ptr <= (grant_id == IdxW'(NumReq - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a packet-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             wfull;
  logic             winc;
  logic [DW-1:0]    wdata;
  logic [1:0]       grant_id;
  logic             busy;
  logic             pkt_done;
  logic             overrun;
  logic             overrun_clr;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NumReq    (NR),
    .DataWidth (DW),
    .MaxBeats  (MAXB)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .wfull       (wfull),
    .winc        (winc),
    .wdata       (wdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // Per-requester pending beats, each {last, data}.
  logic [DW:0]   rq [NR][$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_ptr;
  logic [DW-1:0] exp_w [$];
  int            exp_id [$];
  int            exp_grants;
  bit            exp_over;

  int full_start, full_len, full_pct;
  int gap_req, gap_beat, gap_len, gap_left;
  int clr_beat;
  bit chk_spacing, chk_timing;

  task automatic clear_knobs();
    full_start = 0; full_len = 0; full_pct = 0;
    gap_req = -1; gap_beat = 0; gap_len = 0; gap_left = 0;
    clr_beat = -1; chk_spacing = 0; chk_timing = 0;
  endtask

  task automatic drive_inputs();
    logic [DW:0] h;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && !(i == gap_req && gap_left > 0)) begin
        h = rq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[DW];
        req_data[i*DW +: DW] = h[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    if (gap_left > 0) gap_left--;
  endtask

  task automatic pop_accepted();
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
  endtask

  task automatic add_pkt(input int r, input int len);
    logic [DW:0] w;
    for (int k = 0; k < len; k++) begin
      w[DW-1:0] = 8'($urandom_range(0, 255));
      w[DW]     = (k == len - 1);
      rq[r].push_back(w);
    end
  endtask

  task automatic do_reset();
    clear_knobs();
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive_inputs();
    wfull = 1'b0;
    overrun_clr = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Packet-level model: each grant goes to the first requester with pending data
  // at or after the pointer and runs to its last beat or MAXB beats.
  task automatic build_expected();
    logic [DW:0] cq [NR][$];
    logic [DW:0] w;
    int ptr, g, n;
    bit fin, more;
    for (int i = 0; i < NR; i++) cq[i] = rq[i];
    exp_w.delete(); exp_id.delete();
    exp_grants = 0; exp_over = 0;
    ptr = m_ptr;
    more = 1;
    while (more) begin
      g = -1;
      for (int k = NR - 1; k >= 0; k--)
        if (cq[(ptr + k) % NR].size() > 0) g = (ptr + k) % NR;
      if (g < 0) begin
        more = 0;
      end else begin
        n = 0; fin = 0;
        while (!fin && cq[g].size() > 0) begin
          w = cq[g].pop_front();
          exp_w.push_back(w[DW-1:0]);
          exp_id.push_back(g);
          n++;
          if (w[DW]) fin = 1;
          else if (n == MAXB) begin fin = 1; exp_over = 1; end
        end
        exp_grants++;
        ptr = (g + 1) % NR;
      end
    end
    m_ptr = ptr;
  endtask

  task automatic run_traffic(input string name);
    logic [DW-1:0] got_w [$];
    int got_id [$], got_cyc [$], done_cyc [$];
    int cyc, viol, idle_run, gbeats, nmin;
    bit any_q, gap_on;
    build_expected();
    cyc = 0; viol = 0; idle_run = 0; gbeats = 0; gap_left = 0;
    while (idle_run < 3 && cyc < 4000) begin
      @(negedge wclk);
      overrun_clr = 1'b0;
      if (full_len > 0) wfull = (cyc >= full_start && cyc < full_start + full_len);
      else wfull = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
      gap_on = (gap_left > 0);
      drive_inputs();
      #1;
      if (winc && wfull) viol++;
      if (wfull && req_ready != '0) viol++;
      if ($countones(req_ready) > 1) viol++;
      if (gap_on && !busy) viol++;
      if (pkt_done) done_cyc.push_back(cyc);
      if (winc) begin
        got_w.push_back(wdata);
        got_id.push_back(int'(grant_id));
        got_cyc.push_back(cyc);
        if (got_w.size() == clr_beat) overrun_clr = 1'b1;
        if (int'(grant_id) == gap_req) begin
          gbeats++;
          if (gbeats == gap_beat) gap_left = gap_len;
        end
      end
      pop_accepted();
      any_q = 0;
      for (int i = 0; i < NR; i++) if (rq[i].size() > 0) any_q = 1;
      idle_run = (!any_q && !busy) ? idle_run + 1 : 0;
      cyc++;
    end
    n_checks++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL %s timeout: ran %0d cycles, required drain before 4000", name, cyc);
    end
    n_checks++;
    if (got_w.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d required %0d", name, got_w.size(), exp_w.size());
    end
    nmin = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < nmin; i++) begin
      n_checks++;
      if (got_w[i] !== exp_w[i] || got_id[i] != exp_id[i]) begin
        n_fail++;
        $display("FAIL %s beat%0d: got req%0d data %02h required req%0d data %02h",
                 name, i, got_id[i], got_w[i], exp_id[i], exp_w[i]);
      end
    end
    n_checks++;
    if (done_cyc.size() != exp_grants) begin
      n_fail++;
      $display("FAIL %s pkt_done_count: got %0d required %0d", name, done_cyc.size(), exp_grants);
    end
    n_checks++;
    if (overrun !== exp_over) begin
      n_fail++;
      $display("FAIL %s overrun: got %0b required %0b", name, overrun, exp_over);
    end
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL %s handshake_rules: got %0d violations required 0", name, viol);
    end
    if (chk_spacing) begin
      for (int i = 1; i < got_cyc.size(); i++) begin
        n_checks++;
        if (got_cyc[i] - got_cyc[i-1] != 2) begin
          n_fail++;
          $display("FAIL %s grant_spacing%0d: got %0d cycles required 2", name, i,
                   got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    if (chk_timing && got_cyc.size() > 0 && done_cyc.size() > 0) begin
      n_checks++;
      if (got_cyc[0] != 1) begin
        n_fail++;
        $display("FAIL %s first_beat_cycle: got %0d required 1", name, got_cyc[0]);
      end
      n_checks++;
      if (done_cyc[0] != got_cyc[got_cyc.size()-1] + 1) begin
        n_fail++;
        $display("FAIL %s pkt_done_cycle: got %0d required %0d", name, done_cyc[0],
                 got_cyc[got_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_reset();
    clear_knobs();
    wrst_n = 1'b1;
    wfull = 1'b0;
    overrun_clr = 1'b0;
    req_valid = '1;
    req_last = '0;
    req_data = '1;
    #2;
    wrst_n = 1'b0;
    #1;
    n_checks++;
    if (winc !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_write: got winc %0b ready %b required 0 0000", winc, req_ready);
    end
    n_checks++;
    if (busy !== 1'b0 || pkt_done !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy %0b done %0b ovr %0b required 0 0 0",
               busy, pkt_done, overrun);
    end
    n_checks++;
    if (grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_grant: got %0d required 0", grant_id);
    end
    @(negedge wclk);
    @(negedge wclk);
    n_checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got ready %b busy %0b required 0000 0", req_ready, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    add_pkt(2, 3);
    chk_timing = 1;
    run_traffic("single");
    chk_timing = 0;
    add_pkt(1, 1);
    add_pkt(3, 1);
    run_traffic("after_single_ptr");
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < NR; r++) begin
      add_pkt(r, 1);
      add_pkt(r, 1);
    end
    chk_spacing = 1;
    run_traffic("fairness");
  endtask

  task automatic test_backpressure();
    do_reset();
    add_pkt(1, 16);
    add_pkt(2, 3);
    full_start = 4;
    full_len = 5;
    run_traffic("backpressure");
  endtask

  task automatic test_overrun();
    do_reset();
    add_pkt(0, 20);
    add_pkt(1, 2);
    add_pkt(3, 1);
    run_traffic("overrun");
    @(negedge wclk);
    overrun_clr = 1'b1;
    @(negedge wclk);
    overrun_clr = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %0b required 0", overrun);
    end
    add_pkt(0, 17);
    clr_beat = 16;
    run_traffic("overrun_set_wins");
  endtask

  task automatic test_reset_mid();
    int beats, guard;
    do_reset();
    add_pkt(0, 1);
    run_traffic("rst_pre");
    add_pkt(2, 5);
    beats = 0; guard = 0;
    while (beats < 2 && guard < 50) begin
      @(negedge wclk);
      wfull = 1'b0;
      drive_inputs();
      #1;
      if (winc) beats++;
      pop_accepted();
      guard++;
    end
    n_checks++;
    if (beats != 2) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got %0d beats required 2", beats);
    end
    @(negedge wclk);
    drive_inputs();
    #1;
    wrst_n = 1'b0;
    #1;
    n_checks++;
    if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got winc %0b busy %0b ready %b required 0 0 0000",
               winc, busy, req_ready);
    end
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive_inputs();
    m_ptr = 0;
    @(negedge wclk);
    wrst_n = 1'b1;
    add_pkt(3, 1);
    add_pkt(1, 2);
    run_traffic("rst_post");
  endtask

  task automatic test_valid_gap();
    do_reset();
    add_pkt(1, 6);
    add_pkt(2, 2);
    gap_req = 1;
    gap_beat = 2;
    gap_len = 4;
    run_traffic("valid_gap");
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int r = 0; r < NR; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(1, 20));
      end
      add_pkt($urandom_range(0, NR - 1), $urandom_range(1, 20));
      full_pct = 30;
      run_traffic("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_valid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
